// File: rtl/pipe_pkg.sv
// Shared constants and types for the multi-cycle pipeline hazard unit.
package pipe_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int unsigned PC_REG = 15;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; synchronous active-high clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_count = r_cnt;

endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use / branch / PC-write control,
// multi-cycle data memory stall with a sticky timeout watchdog, and saturating perf counters.
module hazard_unit_mc #(
   parameter int unsigned RW      = 4,
   parameter int unsigned NSRC    = 3,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNTW    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NSRC*RW-1:0] RAD,
   input  logic [NSRC*RW-1:0] RAE,
   input  logic [RW-1:0]      WA3E,
   input  logic [RW-1:0]      WA3M,
   input  logic [RW-1:0]      WA3W,
   input  logic               RegWriteE,
   input  logic               RegWriteM,
   input  logic               RegWriteW,
   input  logic               MemtoRegE,
   input  logic               MemReqM,
   input  logic               MemReadyM,
   input  logic               BranchTakenE,
   input  logic               PCWrPendingF,
   input  logic               PCSrcW,
   output logic [NSRC*2-1:0]  ForwardE,
   output logic               StallF,
   output logic               StallD,
   output logic               StallE,
   output logic               StallM,
   output logic               FlushD,
   output logic               FlushE,
   output logic               FlushW,
   output logic               MemTimeout,
   output logic [CNTW-1:0]    StallCnt,
   output logic [CNTW-1:0]    FlushCnt
);

   import pipe_pkg::*;

   localparam int unsigned WCW = $clog2(TIMEOUT) + 1;

   mem_state_e          r_state;
   logic [WCW-1:0]      r_wait_cnt;
   logic                r_timeout;

   logic [NSRC*2-1:0]   w_fwd;
   logic [NSRC-1:0]     w_ld_match;
   logic                w_mem_stall;
   logic                w_ld_stall;
   logic                w_stall_f, w_stall_d, w_stall_e, w_stall_m;
   logic                w_flush_d, w_flush_e, w_flush_w;

   for (genvar i = 0; i < NSRC; i++) begin : g_cmp
      logic [RW-1:0] w_rae;
      logic          w_is_pc;
      logic          w_hit_m;
      logic          w_hit_w;

      assign w_rae   = RAE[i*RW +: RW];
      assign w_is_pc = (w_rae == RW'(PC_REG));
      assign w_hit_m = RegWriteM & (w_rae == WA3M);
      assign w_hit_w = RegWriteW & (w_rae == WA3W);

      // PC reads come from the fetch path, so they never take a forwarded value.
      assign w_fwd[i*2 +: 2] = w_is_pc ? FWD_RF :
                               w_hit_m ? FWD_M  :
                               w_hit_w ? FWD_W  : FWD_RF;

      assign w_ld_match[i] = (RAD[i*RW +: RW] == WA3E);
   end

   assign w_mem_stall = MemReqM & ~MemReadyM & ~r_timeout;
   assign w_ld_stall  = MemtoRegE & RegWriteE & (|w_ld_match);

   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_w = 1'b0;
      if (!reset) begin
         if (w_mem_stall) begin
            // Freeze F..M; branch and load-use in E are simply held until memory completes.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
         end else begin
            w_stall_d = w_ld_stall;
            w_stall_f = w_ld_stall | PCWrPendingF;
            w_flush_e = w_ld_stall | BranchTakenE;
            w_flush_d = PCWrPendingF | PCSrcW | BranchTakenE;
         end
      end
   end

   assign ForwardE   = reset ? '0 : w_fwd;
   assign StallF     = w_stall_f;
   assign StallD     = w_stall_d;
   assign StallE     = w_stall_e;
   assign StallM     = w_stall_m;
   assign FlushD     = w_flush_d;
   assign FlushE     = w_flush_e;
   assign FlushW     = w_flush_w;
   assign MemTimeout = r_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mem_stall) begin
                  r_state    <= WAIT;
                  r_wait_cnt <= WCW'(1);
               end
            end
            WAIT: begin
               if (!MemReqM || MemReadyM) begin
                  r_state    <= IDLE;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
                  r_state    <= IDLE;
                  r_wait_cnt <= '0;
                  r_timeout  <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNTW)
   ) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_stall_d),
      .o_count (StallCnt)
   );

   sat_counter #(
      .W (CNTW)
   ) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_flush_e),
      .o_count (FlushCnt)
   );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (RW=4, NSRC=3, TIMEOUT=4, CNTW=3).
module tb_hazard_unit_mc;

   logic        clk;
   logic        reset;
   logic [11:0] RAD, RAE;
   logic [3:0]  WA3E, WA3M, WA3W;
   logic        RegWriteE, RegWriteM, RegWriteW;
   logic        MemtoRegE, MemReqM, MemReadyM;
   logic        BranchTakenE, PCWrPendingF, PCSrcW;
   logic [5:0]  ForwardE;
   logic        StallF, StallD, StallE, StallM;
   logic        FlushD, FlushE, FlushW;
   logic        MemTimeout;
   logic [2:0]  StallCnt, FlushCnt;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   hazard_unit_mc #(
      .RW      (4),
      .NSRC    (3),
      .TIMEOUT (4),
      .CNTW    (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .RAD          (RAD),
      .RAE          (RAE),
      .WA3E         (WA3E),
      .WA3M         (WA3M),
      .WA3W         (WA3W),
      .RegWriteE    (RegWriteE),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegE    (MemtoRegE),
      .MemReqM      (MemReqM),
      .MemReadyM    (MemReadyM),
      .BranchTakenE (BranchTakenE),
      .PCWrPendingF (PCWrPendingF),
      .PCSrcW       (PCSrcW),
      .ForwardE     (ForwardE),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushW       (FlushW),
      .MemTimeout   (MemTimeout),
      .StallCnt     (StallCnt),
      .FlushCnt     (FlushCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      RAD          = '0;
      RAE          = '0;
      WA3E         = '0;
      WA3M         = '0;
      WA3W         = '0;
      RegWriteE    = 1'b0;
      RegWriteM    = 1'b0;
      RegWriteW    = 1'b0;
      MemtoRegE    = 1'b0;
      MemReqM      = 1'b0;
      MemReadyM    = 1'b0;
      BranchTakenE = 1'b0;
      PCWrPendingF = 1'b0;
      PCSrcW       = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}
   function automatic logic [6:0] ctl();
      return {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE};
   endfunction

   initial begin
      clear_inputs();
      reset = 1'b1;
      // Hazard-inducing inputs during reset must not reach the stall/flush outputs.
      MemReqM      = 1'b1;
      MemtoRegE    = 1'b1;
      RegWriteE    = 1'b1;
      BranchTakenE = 1'b1;
      tick();
      tick();
      chk("rst_ctl", ctl(), 7'b0000000);
      chk("rst_stallcnt", StallCnt, 0);
      chk("rst_flushcnt", FlushCnt, 0);
      chk("rst_timeout", MemTimeout, 0);
      chk("rst_fwd", ForwardE, 0);
      clear_inputs();
      reset = 1'b0;

      // 1: forwarding
      RAE = {4'd15, 4'd9, 4'd3};
      WA3M = 4'd3; RegWriteM = 1'b1;
      WA3W = 4'd3; RegWriteW = 1'b1;
      #1;
      chk("fwd_m_prio", ForwardE, 6'b000010);
      RegWriteM = 1'b0;
      #1;
      chk("fwd_w", ForwardE, 6'b000001);
      RegWriteM = 1'b1; WA3W = 4'd9;
      #1;
      chk("fwd_mixed", ForwardE, 6'b000110);
      RAE = {4'd15, 4'd15, 4'd15}; WA3M = 4'd15; WA3W = 4'd15;
      #1;
      chk("fwd_pc", ForwardE, 6'b000000);
      chk("fwd_nostall", ctl(), 7'b0000000);
      tick();

      // 2: load-use on operand 2
      clear_inputs();
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5;
      RAD = {4'd5, 4'd0, 4'd1};
      #1;
      chk("ldu_ctl", ctl(), 7'b1100001);
      tick();
      clear_inputs();
      #1;
      chk("ldu_stallcnt", StallCnt, 1);
      chk("ldu_flushcnt", FlushCnt, 1);
      chk("ldu_gone", ctl(), 7'b0000000);
      MemtoRegE = 1'b1; RegWriteE = 1'b0; WA3E = 4'd5; RAD = {4'd5, 4'd0, 4'd0};
      #1;
      chk("ldu_nowrite", ctl(), 7'b0000000);

      // 3: branch with PC write pending, then PC retire alone
      clear_inputs();
      BranchTakenE = 1'b1; PCWrPendingF = 1'b1;
      #1;
      chk("br_pc_ctl", ctl(), 7'b1000011);
      clear_inputs();
      PCSrcW = 1'b1;
      #1;
      chk("pcsrcw_ctl", ctl(), 7'b0000010);
      tick();

      // 4: three-cycle memory wait with a concurrent taken branch
      clear_inputs();
      do_reset();
      MemReqM = 1'b1; BranchTakenE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("memwait_ctl%0d", i), ctl(), 7'b1111100);
         tick();
      end
      MemReadyM = 1'b1;
      #1;
      chk("memrdy_ctl", ctl(), 7'b0000011);
      chk("memrdy_stallcnt", StallCnt, 3);
      chk("memrdy_flushcnt", FlushCnt, 0);
      tick();
      chk("memrdy_flushcnt2", FlushCnt, 1);
      chk("memrdy_timeout", MemTimeout, 0);

      // 5: watchdog after four stall cycles, sticky until reset
      clear_inputs();
      do_reset();
      MemReqM = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("wd_stall%0d", i), StallM, 1);
         tick();
      end
      chk("wd_timeout", MemTimeout, 1);
      chk("wd_released", ctl(), 7'b0000000);
      chk("wd_stallcnt", StallCnt, 4);
      MemReadyM = 1'b1;
      tick();
      MemReadyM = 1'b0;
      tick();
      chk("wd_sticky", MemTimeout, 1);
      chk("wd_sticky_nostall", StallM, 0);
      do_reset();
      #1;
      chk("wd_cleared", MemTimeout, 0);
      chk("wd_restall", StallM, 1);

      // 6: saturation, then reset mid-WAIT
      clear_inputs();
      do_reset();
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RAD = {4'd0, 4'd5, 4'd0};
      for (int i = 0; i < 9; i++) tick();
      chk("sat_stallcnt", StallCnt, 7);
      chk("sat_flushcnt", FlushCnt, 7);
      clear_inputs();
      MemReqM = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midwait_rst_ctl", ctl(), 7'b0000000);
      tick();
      chk("midwait_stallcnt", StallCnt, 0);
      chk("midwait_flushcnt", FlushCnt, 0);
      chk("midwait_timeout", MemTimeout, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("midwait_fsm_idle_a", MemTimeout, 0);
      tick();
      chk("midwait_fsm_idle_b", MemTimeout, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
